// File: rtl/pipeline_pkg.sv
// Shared definitions for the elastic pipeline stage: size limits, occupancy
// counter width derivation and the inter-slot handshake record.
package pipeline_pkg;

  localparam int WIDTH_MAX = 256;
  localparam int DEPTH_MAX = 8;

  // One inter-slot link; data is padded to WIDTH_MAX, only the low WIDTH bits carry payload.
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_MAX-1:0] data;
  } slot_hs_t;

  // Counter must hold 0..2*depth; out-of-range depths are clamped to the supported range.
  function automatic int cntw(input int depth);
    int d;
    d = (depth > DEPTH_MAX) ? DEPTH_MAX : ((depth < 1) ? 1 : depth);
    return $clog2(2 * d + 1);
  endfunction

endpackage

// File: rtl/pipeline_skid_stage_slot.sv
// pipeline_skid_slot: one main+skid elastic slot. PIPELINE_SKID_FLUSH_EN adds
// the flush input that empties both registers.
module pipeline_skid_slot
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PIPELINE_SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  // Handshake: a transfer happens on a posedge where valid && ready; the sender
  // holds valid/data until it happens, and ready never depends on valid.
  logic             vm;
  logic             vs;
  logic [WIDTH-1:0] dm;
  logic [WIDTH-1:0] ds;
  logic             in_fire;

  assign in_fire   = in_valid && !vs;
  assign in_ready  = !vs;
  assign out_valid = vm;
  assign out_data  = dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vm <= 1'b0;
      vs <= 1'b0;
      dm <= '0;
      ds <= '0;
    end
`ifdef PIPELINE_SKID_FLUSH_EN
    else if (flush) begin
      vm <= 1'b0;
      vs <= 1'b0;
    end
`endif
    else begin
      if (!vm || out_ready) begin
        // Skid drains first so ordering stays FIFO; in_ready was low while vs was set.
        if (vs) begin
          vm <= 1'b1;
          dm <= ds;
          vs <= 1'b0;
        end else if (in_fire) begin
          vm <= 1'b1;
          dm <= in_data;
        end else begin
          vm <= 1'b0;
        end
      end else if (in_fire) begin
        vs <= 1'b1;
        ds <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipeline_skid_stage.sv
// pipeline_skid_stage: DEPTH cascaded skid slots plus an occupancy counter.
// Define PIPELINE_SKID_FLUSH_EN to make the flush port discard all entries.
module pipeline_skid_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int CNTW  = cntw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNTW-1:0]  occupancy
);

  slot_hs_t [DEPTH:0] link;
  logic     [DEPTH:0] rdy;
  logic               in_fire;
  logic               out_fire;
  logic [CNTW-1:0]    occ_q;
  logic               unused_link;

  assign link[0]    = '{valid: in_valid, data: WIDTH_MAX'(in_data)};
  assign rdy[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic             slot_valid;
    logic [WIDTH-1:0] slot_data;

    pipeline_skid_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
`ifdef PIPELINE_SKID_FLUSH_EN
      .flush     (flush),
`endif
      .rst       (rst),
      .in_valid  (link[k].valid),
      .in_data   (link[k].data[WIDTH-1:0]),
      .in_ready  (rdy[k]),
      .out_valid (slot_valid),
      .out_data  (slot_data),
      .out_ready (rdy[k+1])
    );

    assign link[k+1] = '{valid: slot_valid, data: WIDTH_MAX'(slot_data)};
  end

  assign in_ready  = rdy[0];
  assign out_valid = link[DEPTH].valid;
  assign out_data  = link[DEPTH].data[WIDTH-1:0];
  assign occupancy = occ_q;

  // Padding bits above WIDTH are constant zero and intentionally unread.
  assign unused_link = ^link;

  // Internal slot-to-slot moves never change the total, so only the boundary fires count.
  assign in_fire  = in_valid && rdy[0];
  assign out_fire = link[DEPTH].valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end
`ifdef PIPELINE_SKID_FLUSH_EN
    else if (flush) begin
      occ_q <= '0;
    end
`endif
    else if (in_fire && !out_fire) begin
      occ_q <= occ_q + 1'b1;
    end else if (!in_fire && out_fire) begin
      occ_q <= occ_q - 1'b1;
    end
  end

`ifndef PIPELINE_SKID_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Self-checking bench for pipeline_skid_stage: a DEPTH=2 and a DEPTH=3 instance,
// FIFO scoreboard per instance, per-cycle occupancy model.
module tb_pipeline_skid_stage;
  import pipeline_pkg::*;

  localparam int W  = 16;
  localparam int D0 = 2;
  localparam int D1 = 3;
  localparam int C0 = cntw(D0);
  localparam int C1 = cntw(D1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         in_valid  [2];
  logic [W-1:0] in_data   [2];
  logic         in_ready  [2];
  logic         out_valid [2];
  logic [W-1:0] out_data  [2];
  logic         out_ready [2];
  logic         flush     [2];
  logic [C0-1:0] occ0;
  logic [C1-1:0] occ1;

  pipeline_skid_stage #(.WIDTH(W), .DEPTH(D0)) u_dut_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .flush(flush[0]), .occupancy(occ0)
  );

  pipeline_skid_stage #(.WIDTH(W), .DEPTH(D1)) u_dut_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .flush(flush[1]), .occupancy(occ1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int stamp_q0[$];
  int stamp_q1[$];
  int   occ_m   [2];
  bit   chk_lat [2];
  logic hold    [2];
  logic [W-1:0] held_d [2];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int occ_of(input int i);
    return (i == 0) ? int'(occ0) : int'(occ1);
  endfunction

  function automatic void q_push(input int i, input logic [W-1:0] d);
    if (i == 0) begin exp_q0.push_back(d); stamp_q0.push_back(cyc); end
    else        begin exp_q1.push_back(d); stamp_q1.push_back(cyc); end
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void q_clear(input int i);
    if (i == 0) begin exp_q0.delete(); stamp_q0.delete(); end
    else        begin exp_q1.delete(); stamp_q1.delete(); end
  endfunction

  // Monitor step: sampled mid-cycle, describes the fires of the coming posedge.
  function automatic void mon_step(input int i);
    logic         in_f, out_f, fl;
    logic [W-1:0] ed;
    int           es;
    check($sformatf("occupancy[%0d]", i), occ_of(i), occ_m[i]);
    if (hold[i]) check($sformatf("in_data_stable[%0d]", i), in_data[i], held_d[i]);
    hold[i]   = in_valid[i] && !in_ready[i];
    held_d[i] = in_data[i];
    in_f  = in_valid[i] && in_ready[i];
    out_f = out_valid[i] && out_ready[i];
`ifdef PIPELINE_SKID_FLUSH_EN
    fl = flush[i];
`else
    fl = 1'b0;
`endif
    if (out_f) begin
      if (q_size(i) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output[%0d]: actual %0h required none", i, out_data[i]);
      end else begin
        if (i == 0) begin ed = exp_q0.pop_front(); es = stamp_q0.pop_front(); end
        else        begin ed = exp_q1.pop_front(); es = stamp_q1.pop_front(); end
        check($sformatf("out_data[%0d]", i), out_data[i], ed);
        if (chk_lat[i]) check($sformatf("latency[%0d]", i), cyc - es, depth_of(i));
      end
    end
    if (fl) occ_m[i] = 0;
    else    occ_m[i] = occ_m[i] + int'(in_f) - int'(out_f);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        q_clear(i);
        occ_m[i] = 0;
        hold[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) mon_step(i);
    end
  end

  // ---------------- driver tasks ----------------
  // Pushes first..first+n-1 into instance i; expected data is queued on acceptance.
  task automatic stream(input int i, input int first, input int n, input int budget,
                        input bit gaps, output int acc_o, output int lo_o);
    int used;
    bit took;
    used  = 0;
    acc_o = 0;
    lo_o  = 0;
    while (acc_o < n && used < budget) begin
      if (!in_valid[i]) begin
        in_valid[i] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data[i]  = W'(first + acc_o);
      end
      @(negedge clk);
      took = in_valid[i] && in_ready[i];
      if (!in_ready[i]) lo_o++;
      if (took) begin
        q_push(i, in_data[i]);
        acc_o++;
      end
      @(posedge clk); #1;
      if (took) in_valid[i] = 1'b0;
      used++;
    end
    in_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i, input int budget);
    int c;
    c = 0;
    while ((q_size(i) != 0 || out_valid[i]) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check($sformatf("drain_left[%0d]", i), q_size(i), 0);
    check($sformatf("drain_occ[%0d]", i), occ_of(i), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  int acc, lo;
  bit rand_on;

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1; flush[i] = 1'b0;
      chk_lat[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
      check($sformatf("rst_out_data[%0d]", i), out_data[i], 0);
      check($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
      check($sformatf("rst_occ[%0d]", i), occ_of(i), 0);
    end
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    // Mid-stream reset with two entries held
    out_ready[0] = 1'b0;
    stream(0, 'h11, 2, 10, 1'b0, acc, lo);
    check("fill_two_acc", acc, 2);
    check("fill_two_occ", occ0, 2);
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid[0], 0);
    check("midrst_occ", occ0, 0);
    check("midrst_in_ready", in_ready[0], 1);
    @(posedge clk); #3;
    rst = 1'b1;
    out_ready[0] = 1'b1;
    chk_lat[0] = 1'b1;
    stream(0, 'hA5, 1, 1, 1'b0, acc, lo);
    check("first_edge_accept", acc, 1);
    drain(0, 20);
    chk_lat[0] = 1'b0;

    // Streaming on DEPTH=3: one per cycle, fixed latency, in_ready never low
    chk_lat[1] = 1'b1;
    stream(1, 0, 100, 100, 1'b0, acc, lo);
    check("stream_acc", acc, 100);
    check("stream_in_ready_low", lo, 0);
    drain(1, 20);
    chk_lat[1] = 1'b0;

    // Backpressure on DEPTH=2: four entries fit, then resume
    out_ready[0] = 1'b0;
    stream(0, 1, 10, 10, 1'b0, acc, lo);
    check("bp_acc", acc, 4);
    check("bp_occ", occ0, 4);
    check("bp_in_ready", in_ready[0], 0);
    check("bp_out_data", out_data[0], 1);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_occ1", occ0, 3);
    @(posedge clk); #1;
    check("bp_release_occ2", occ0, 2);
    check("bp_release_in_ready", in_ready[0], 1);
    stream(0, 5, 6, 30, 1'b0, acc, lo);
    check("bp_rest_acc", acc, 6);
    drain(0, 30);

    // Random stalls on both sides
    rand_on = 1'b1;
    fork
      begin
        stream(0, 'h1000, 10000, 40000, 1'b1, acc, lo);
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready[0] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    check("rand_acc", acc, 10000);
    out_ready[0] = 1'b1;
    drain(0, 50);

    // Flush with a simultaneous input
    out_ready[0] = 1'b0;
    stream(0, 'h31, 3, 10, 1'b0, acc, lo);
    check("flush_fill_occ", occ0, 3);
    flush[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 'h55;
    @(negedge clk);
`ifdef PIPELINE_SKID_FLUSH_EN
    q_clear(0);
`else
    check("flush_ignored_in_ready", in_ready[0], 1);
    q_push(0, 'h55);
`endif
    @(posedge clk); #1;
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
`ifdef PIPELINE_SKID_FLUSH_EN
    check("flush_occ", occ0, 0);
    check("flush_out_valid", out_valid[0], 0);
    check("flush_in_ready", in_ready[0], 1);
`else
    check("noflush_occ", occ0, 4);
    check("noflush_out_data", out_data[0], 'h31);
`endif
    out_ready[0] = 1'b1;
    drain(0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
